rpsc_fault_sequencer: RTL

Controller for an RPSC protection card's fault flip-flops (8 channels, FF41..FF48 style).
- Synchronises and debounces raw fault inputs.
- Latches alarms per channel and records the first-out fault.
- Drives a card trip.
- Sequences the operator acknowledge/reset so latches clear only after all unmasked faults have been inactive for a hold time.
- Sits between the card's fault inputs and the per-channel OUT/LA outputs.

---
 rtl/rpsc_pkg.sv | 15 +
 rtl/rpsc_debounce.sv | 60 ++++++
 rtl/rpsc_fault_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/rpsc_pkg.sv
// Shared types and constants for the RPSC fault sequencer.
package rpsc_pkg;

  // Channel count of the card-12 protection card (FF41..FF48).
  localparam int CARD12_N_CH = 8;

  // Acknowledge/reset sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TRIPPED = 2'd1,
    ST_CHECK   = 2'd2,
    ST_CLEAR   = 2'd3
  } rpsc_state_e;

endpackage

// File: rtl/rpsc_debounce.sv
// One fault channel: multi-stage synchroniser followed by a debounce counter.
// dout_next is the value dout will take at the next edge, so downstream
// latches can register the same event in the same cycle dout changes.
module rpsc_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic dout_next
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   out_q, out_d;
  logic                   synced;

  // Shift the raw input through the synchroniser chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    synced = sync_q[SYNC_STAGES-1];
  end

  // Count consecutive differing samples; toggle on the DEBOUNCE-th one.
  // The counter restarts on every toggle, so it never passes CNT_LAST.
  always_comb begin
    cnt_d = cnt_q;
    out_d = out_q;
    if (synced == out_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CNT_LAST) begin
      out_d = ~out_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Synchroniser, counter and debounced output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
      out_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
    end
  end

  assign dout      = out_q;
  assign dout_next = out_d;

endmodule

// File: rtl/rpsc_fault_sequencer.sv
// RPSC fault flip-flop controller: debounced live faults, per-channel alarm
// latches with first-out capture, card trip, and the acknowledge/clear
// sequence that only releases latches after a fault-free hold time.
module rpsc_fault_sequencer
  import rpsc_pkg::*;
#(
  parameter int N_CH        = CARD12_N_CH,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int HOLD_CYCLES = 16,
  localparam int IW         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] fault_in,
  input  logic [N_CH-1:0] fault_mask,
  input  logic            ack_req,
  output logic [N_CH-1:0] fault_out,
  output logic [N_CH-1:0] fault_la,
  output logic            first_valid,
  output logic [IW-1:0]   first_idx,
  output logic            trip,
  output logic            busy,
  output logic            clear_denied
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  logic [N_CH-1:0] fault_next;
  logic [N_CH-1:0] set_vec;
  logic [N_CH-1:0] active;
  logic [IW-1:0]   low_idx;
  logic            ack_rise;

  rpsc_state_e     state_q, state_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [N_CH-1:0] la_q, la_d;
  logic            fv_q, fv_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            ack_q, ack_d;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    rpsc_debounce #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE   (DEBOUNCE)
    ) u_debounce (
      .clk      (clk),
      .reset    (reset),
      .din      (fault_in[g]),
      .dout     (fault_out[g]),
      .dout_next(fault_next[g])
    );
  end

  // Latch requests use the debouncer's next value so LA rises with OUT;
  // the hold check looks at the live unmasked OUT state.
  always_comb begin
    set_vec  = fault_next & ~fault_mask;
    active   = fault_out & ~fault_mask;
    ack_d    = ack_req;
    ack_rise = ack_req & ~ack_q;
    low_idx  = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (set_vec[i]) low_idx = IW'(i);
    end
  end

  // Next-state and hold counter logic for the acknowledge sequence.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|set_vec) state_d = ST_TRIPPED;
      end
      ST_TRIPPED: begin
        if (ack_rise) begin
          state_d = ST_CHECK;
          hold_d  = '0;
        end
      end
      ST_CHECK: begin
        if (|active) begin
          state_d = ST_TRIPPED;
        end else begin
          hold_d = hold_q + 1'b1;
          if (hold_q >= HOLD_LAST) state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        state_d = (|set_vec) ? ST_TRIPPED : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Alarm latches and first-out capture; a set in the CLEAR cycle survives.
  always_comb begin
    if (state_q == ST_CLEAR) begin
      la_d  = set_vec;
      fv_d  = 1'b0;
      idx_d = '0;
    end else begin
      la_d  = la_q | set_vec;
      fv_d  = fv_q;
      idx_d = idx_q;
    end
    if (!fv_d && (|set_vec)) begin
      fv_d  = 1'b1;
      idx_d = low_idx;
    end
  end

  // Decode status outputs from the current state and latch registers.
  always_comb begin
    trip         = |la_q;
    busy         = (state_q == ST_CHECK) || (state_q == ST_CLEAR);
    clear_denied = (state_q == ST_CHECK) && (|active);
  end

  // State, hold counter, latches, first-out and ack edge registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      la_q    <= '0;
      fv_q    <= 1'b0;
      idx_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      la_q    <= la_d;
      fv_q    <= fv_d;
      idx_q   <= idx_d;
      ack_q   <= ack_d;
    end
  end

  assign fault_la    = la_q;
  assign first_valid = fv_q;
  assign first_idx   = idx_q;

endmodule
